// File: rtl/clk_en_pkg.sv
// Shared types and defaults for the clock-enable generator.
// No logic of its own; the helper is pure combinational.
// No flow control.
package clk_en_pkg;

   // Lock state: WAIT while outputs settle, RUN once enables are qualified.
   typedef enum logic {
      WAIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DIV_W_DEF       = 8;
   localparam int LOCK_CYCLES_DEF = 16;

   // Divisors 0 and 1 both mean "strobe every cycle".
   // Divisor widths up to 32 bits are supported.
   function automatic logic [31:0] eff_div(input logic [31:0] div);
      return (div <= 32'd1) ? 32'd1 : div;
   endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One enable channel: wrap counter, divisor with staged update, square reference.
// Zero-latency tc/en decode from registers; staged divisor lands on the next terminal count.
// Writes are refused upstream while a value is still pending (pend_o).
module clk_en_chan
   import clk_en_pkg::*;
#(
   parameter int               DIV_W   = DIV_W_DEF,
   parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(4)
) (
   input  logic             clk100,
   input  logic             rst,
   input  logic             sync_i,
   input  logic             accept_i,
   input  logic [DIV_W-1:0] value_i,
   input  logic             locked_i,
   output logic             tc_o,
   output logic             applied_o,
   output logic             en_o,
   output logic             sq_o,
   output logic             pend_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] pval_q, pval_d;
   logic             pend_q, pend_d;
   logic             sq_q, sq_d;
   logic [DIV_W-1:0] d_eff;
   logic             tc;

   assign d_eff = DIV_W'(eff_div(32'(div_q)));
   assign tc    = (cnt_q == (d_eff - DIV_W'(1)));

   assign tc_o      = tc;
   assign applied_o = pend_q & (tc | sync_i);
   assign en_o      = locked_i & tc;
   assign sq_o      = sq_q;
   assign pend_o    = pend_q;

   // Next state: sync realigns everything and flushes the staged divisor;
   // otherwise the staged divisor only lands on a terminal count, so the
   // period in flight always completes at its old length.
   always_comb begin
      cnt_d  = tc ? '0 : cnt_q + DIV_W'(1);
      div_d  = div_q;
      pend_d = pend_q;
      pval_d = pval_q;
      sq_d   = sq_q ^ tc;
      if (sync_i) begin
         cnt_d  = '0;
         sq_d   = 1'b0;
         pend_d = 1'b0;
         if (pend_q) begin
            div_d = pval_q;
         end
      end else if (tc && pend_q) begin
         div_d  = pval_q;
         pend_d = 1'b0;
      end
      // A new write can only be accepted while nothing is pending, so it
      // never collides with an apply; a write alongside sync stays staged.
      if (accept_i) begin
         pend_d = 1'b1;
         pval_d = value_i;
      end
   end

   // Channel registers with synchronous reset to the build-time divisor.
   always_ff @(posedge clk100) begin
      if (rst) begin
         cnt_q  <= '0;
         div_q  <= DIV_RST;
         pval_q <= '0;
         pend_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         pval_q <= pval_d;
         pend_q <= pend_d;
         sq_q   <= sq_d;
      end
   end

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator: NUM_CH divided strobes plus square references off clk100.
// en is decoded from registers with zero added latency; locked drops for LOCK_CYCLES after any change.
// div_wr_ready falls per channel while a write is staged; out-of-range channels are always ready.
module clk_en_gen
   import clk_en_pkg::*;
#(
   parameter int                      NUM_CH      = 2,
   parameter int                      DIV_W       = DIV_W_DEF,
   parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = {8'd2, 8'd4},
   parameter int                      LOCK_CYCLES = LOCK_CYCLES_DEF,
   localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk100,
   input  logic              rst,
   input  logic              div_wr_valid,
   output logic              div_wr_ready,
   input  logic [CH_W-1:0]   div_wr_ch,
   input  logic [DIV_W-1:0]  div_wr_val,
   input  logic              sync_req,
   output logic [NUM_CH-1:0] en,
   output logic [NUM_CH-1:0] sq,
   output logic              locked
);

   localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   state_t            state_q, state_d;
   logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic              locked_q, locked_d;

   logic [NUM_CH-1:0] accept_ch;
   logic [NUM_CH-1:0] tc_w, applied_w, en_w, sq_w, pend_w;
   logic              sel_pend;
   logic              accept;
   logic              relock;
   logic              chan_locked;

   // Ready mux: a channel outside the populated range has nothing pending.
   always_comb begin
      sel_pend = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (div_wr_ch == CH_W'(i)) begin
            sel_pend = pend_w[i];
         end
      end
   end

   assign div_wr_ready = ~rst & ~sel_pend;
   assign accept       = div_wr_valid & div_wr_ready;

   // Channel decode of an accepted write; out-of-range writes hit no channel.
   always_comb begin
      accept_ch = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         accept_ch[i] = accept & (div_wr_ch == CH_W'(i));
      end
   end

   // Enables are held off while in reset even if the lock register is still set.
   assign chan_locked = locked_q & ~rst;
   assign relock      = sync_req | (|applied_w);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_en_chan #(
         .DIV_W   (DIV_W),
         .DIV_RST (DIV_INIT[i*DIV_W +: DIV_W])
      ) u_chan (
         .clk100    (clk100),
         .rst       (rst),
         .sync_i    (sync_req),
         .accept_i  (accept_ch[i]),
         .value_i   (div_wr_val),
         .locked_i  (chan_locked),
         .tc_o      (tc_w[i]),
         .applied_o (applied_w[i]),
         .en_o      (en_w[i]),
         .sq_o      (sq_w[i]),
         .pend_o    (pend_w[i])
      );
   end

   assign en     = en_w;
   assign sq     = sq_w;
   assign locked = locked_q;

   // Lock FSM next state: count out the settle window, restart it on any change.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      case (state_q)
         WAIT: begin
            if (relock) begin
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) begin
               state_d    = RUN;
               locked_d   = 1'b1;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + LC_W'(1);
            end
         end
         RUN: begin
            if (relock) begin
               state_d    = WAIT;
               lock_cnt_d = '0;
               locked_d   = 1'b0;
            end
         end
         default: begin
            state_d    = WAIT;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
         end
      endcase
   end

   // Lock FSM registers with synchronous reset.
   always_ff @(posedge clk100) begin
      if (rst) begin
         state_q    <= WAIT;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   // Invariant: a strobe only ever appears on a terminal count while locked.
   always_ff @(posedge clk100) begin
      if (!rst) begin
         assert ((en_w & ~(tc_w & {NUM_CH{locked_q}})) == '0);
      end
   end

endmodule

// File: tb/tb_clk_en_gen.sv
// Scenario bench for clk_en_gen with default parameters (ch0 /4, ch1 /2, 16-cycle lock).
// Events (strobes, lock edges) are stamped with the cycle number and compared against a sorted expectation queue.
// Cycle 0 is the first cycle after rst is released.
module tb_clk_en_gen;

   logic       clk100 = 1'b0;
   logic       rst;
   logic       div_wr_valid;
   logic       div_wr_ready;
   logic [0:0] div_wr_ch;
   logic [7:0] div_wr_val;
   logic       sync_req;
   logic [1:0] en;
   logic [1:0] sq;
   logic       locked;

   always #5 clk100 = ~clk100;

   clk_en_gen dut (
      .clk100       (clk100),
      .rst          (rst),
      .div_wr_valid (div_wr_valid),
      .div_wr_ready (div_wr_ready),
      .div_wr_ch    (div_wr_ch),
      .div_wr_val   (div_wr_val),
      .sync_req     (sync_req),
      .en           (en),
      .sq           (sq),
      .locked       (locked)
   );

   // Event codes: kind * 10000 + cycle number.
   localparam int K_EN0  = 10000;
   localparam int K_EN1  = 20000;
   localparam int K_RISE = 30000;
   localparam int K_FALL = 40000;

   int         cyc;
   int         n_chk;
   int         n_pass;
   int         obs_q[$];
   int         exp_q[$];
   logic [1:0] s_en, s_sq;
   logic       s_lock, s_rdy, lock_prev;

   // Called just after a rising edge: sample this cycle's outputs, record events,
   // then move to just after the next rising edge.
   task automatic tick();
      #1;
      s_en   = en;
      s_sq   = sq;
      s_lock = locked;
      s_rdy  = div_wr_ready;
      if (en[0]) obs_q.push_back(K_EN0 + cyc);
      if (en[1]) obs_q.push_back(K_EN1 + cyc);
      if (locked && !lock_prev) obs_q.push_back(K_RISE + cyc);
      if (!locked && lock_prev) obs_q.push_back(K_FALL + cyc);
      lock_prev = locked;
      @(posedge clk100);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   // One-edge reset; everything is checked while rst is still high.
   task automatic test_reset();
      rst          = 1'b1;
      div_wr_valid = 1'b0;
      div_wr_ch    = 1'b0;
      div_wr_val   = 8'd0;
      sync_req     = 1'b0;
      @(posedge clk100);
      #1;
      n_chk++; if (en !== 2'b00) $display("FAIL reset_en got=%b exp=00", en); else n_pass++;
      n_chk++; if (div_wr_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", div_wr_ready); else n_pass++;
      n_chk++; if (locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked); else n_pass++;
      n_chk++; if (sq !== 2'b00) $display("FAIL reset_sq got=%b exp=00", sq); else n_pass++;
      rst       = 1'b0;
      cyc       = 0;
      lock_prev = 1'b0;
      obs_q.delete();
   endtask

   task automatic test_default_cadence();
      obs_q.delete();
      exp_q.delete();
      exp_q.push_back(K_RISE + 16);
      for (int c = 19; c <= 27; c += 4) exp_q.push_back(K_EN0 + c);
      for (int c = 17; c <= 29; c += 2) exp_q.push_back(K_EN1 + c);
      for (int c = 0; c < 31; c++) begin
         tick();
         if (c == 0) begin
            n_chk++; if (s_rdy !== 1'b1) $display("FAIL cadence_ready0 got=%b exp=1", s_rdy); else n_pass++;
         end
         if (c % 3 == 0) begin
            n_chk++;
            if (s_sq[0] !== 1'((c / 4) % 2) || s_sq[1] !== 1'((c / 2) % 2))
               $display("FAIL cadence_sq cyc=%0d got=%b exp=%b%b", c, s_sq, 1'((c / 2) % 2), 1'((c / 4) % 2));
            else n_pass++;
         end
      end
      obs_q.sort(); exp_q.sort();
      n_chk++; if (obs_q.size() !== exp_q.size()) $display("FAIL cadence_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL cadence_event[%0d] got=%0d exp=%0d", i, obs_q[i], exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_write_apply();
      run_to(40);
      obs_q.delete();
      exp_q.delete();
      div_wr_valid = 1'b1; div_wr_ch = 1'b0; div_wr_val = 8'd8;
      exp_q.push_back(K_EN0 + 43);
      exp_q.push_back(K_EN0 + 67);
      exp_q.push_back(K_EN0 + 75);
      exp_q.push_back(K_FALL + 44);
      exp_q.push_back(K_RISE + 60);
      exp_q.push_back(K_EN1 + 41);
      exp_q.push_back(K_EN1 + 43);
      for (int c = 61; c <= 79; c += 2) exp_q.push_back(K_EN1 + c);
      tick();
      n_chk++; if (s_rdy !== 1'b1) $display("FAIL wr_ready40 got=%b exp=1", s_rdy); else n_pass++;
      div_wr_valid = 1'b0;
      tick();
      n_chk++; if (s_rdy !== 1'b0) $display("FAIL wr_ready41 got=%b exp=0", s_rdy); else n_pass++;
      run_to(44);
      tick();
      n_chk++; if (s_rdy !== 1'b1) $display("FAIL wr_ready44 got=%b exp=1", s_rdy); else n_pass++;
      run_to(80);
      obs_q.sort(); exp_q.sort();
      n_chk++; if (obs_q.size() !== exp_q.size()) $display("FAIL wr_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL wr_event[%0d] got=%0d exp=%0d", i, obs_q[i], exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      obs_q.delete();
      exp_q.delete();
      div_wr_valid = 1'b1; div_wr_ch = 1'b1; div_wr_val = 8'd3;
      exp_q.push_back(K_EN1 + 81);
      for (int c = 104; c <= 119; c += 5) exp_q.push_back(K_EN1 + c);
      exp_q.push_back(K_EN0 + 107);
      exp_q.push_back(K_EN0 + 115);
      exp_q.push_back(K_FALL + 82);
      exp_q.push_back(K_RISE + 101);
      tick();
      n_chk++; if (s_rdy !== 1'b1) $display("FAIL b2b_ready80 got=%b exp=1", s_rdy); else n_pass++;
      div_wr_val = 8'd5;
      tick();
      n_chk++; if (s_rdy !== 1'b0) $display("FAIL b2b_ready81 got=%b exp=0", s_rdy); else n_pass++;
      tick();
      n_chk++; if (s_rdy !== 1'b1) $display("FAIL b2b_ready82 got=%b exp=1", s_rdy); else n_pass++;
      div_wr_valid = 1'b0;
      tick();
      n_chk++; if (s_rdy !== 1'b0) $display("FAIL b2b_ready83 got=%b exp=0", s_rdy); else n_pass++;
      run_to(120);
      obs_q.sort(); exp_q.sort();
      n_chk++; if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_event[%0d] got=%0d exp=%0d", i, obs_q[i], exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_div_one();
      logic [1:0] prev_sq;
      prev_sq = 2'b00;
      obs_q.delete();
      exp_q.delete();
      div_wr_valid = 1'b1; div_wr_ch = 1'b0; div_wr_val = 8'd0;
      exp_q.push_back(K_EN0 + 123);
      exp_q.push_back(K_FALL + 124);
      exp_q.push_back(K_RISE + 141);
      for (int c = 141; c < 150; c++) begin
         exp_q.push_back(K_EN0 + c);
         exp_q.push_back(K_EN1 + c);
      end
      tick();
      n_chk++; if (s_rdy !== 1'b1) $display("FAIL one_ready120 got=%b exp=1", s_rdy); else n_pass++;
      div_wr_ch = 1'b1; div_wr_val = 8'd1;
      tick();
      n_chk++; if (s_rdy !== 1'b1) $display("FAIL one_ready121 got=%b exp=1", s_rdy); else n_pass++;
      div_wr_valid = 1'b0;
      run_to(141);
      for (int c = 141; c < 150; c++) begin
         tick();
         if (c > 141) begin
            n_chk++; if (s_sq !== ~prev_sq) $display("FAIL one_sq_toggle cyc=%0d got=%b exp=%b", c, s_sq, ~prev_sq); else n_pass++;
         end
         prev_sq = s_sq;
      end
      obs_q.sort(); exp_q.sort();
      n_chk++; if (obs_q.size() !== exp_q.size()) $display("FAIL one_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL one_event[%0d] got=%0d exp=%0d", i, obs_q[i], exp_q[i]); else n_pass++;
      end
   endtask

   // Stage a write, then hit reset while it is still pending.
   task automatic test_reset_mid();
      div_wr_valid = 1'b1; div_wr_ch = 1'b0; div_wr_val = 8'd7;
      tick();
      div_wr_valid = 1'b0;
      test_reset();
   endtask

   task automatic test_sync();
      run_to(32);
      obs_q.delete();
      exp_q.delete();
      div_wr_valid = 1'b1; div_wr_ch = 1'b0; div_wr_val = 8'd6;
      exp_q.push_back(K_EN1 + 33);
      exp_q.push_back(K_FALL + 35);
      exp_q.push_back(K_RISE + 51);
      exp_q.push_back(K_EN0 + 52);
      exp_q.push_back(K_EN0 + 58);
      for (int c = 52; c <= 60; c += 2) exp_q.push_back(K_EN1 + c);
      tick();
      n_chk++; if (s_rdy !== 1'b1) $display("FAIL sync_ready32 got=%b exp=1", s_rdy); else n_pass++;
      div_wr_valid = 1'b0;
      tick();
      n_chk++; if (s_rdy !== 1'b0) $display("FAIL sync_ready33 got=%b exp=0", s_rdy); else n_pass++;
      sync_req = 1'b1;
      tick();
      sync_req = 1'b0;
      tick();
      n_chk++; if (s_sq !== 2'b00) $display("FAIL sync_sq35 got=%b exp=00", s_sq); else n_pass++;
      n_chk++; if (s_rdy !== 1'b1) $display("FAIL sync_ready35 got=%b exp=1", s_rdy); else n_pass++;
      n_chk++; if (s_lock !== 1'b0) $display("FAIL sync_locked35 got=%b exp=0", s_lock); else n_pass++;
      run_to(61);
      obs_q.sort(); exp_q.sort();
      n_chk++; if (obs_q.size() !== exp_q.size()) $display("FAIL sync_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[i] !== exp_q[i]) $display("FAIL sync_event[%0d] got=%0d exp=%0d", i, obs_q[i], exp_q[i]); else n_pass++;
      end
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      cyc       = 0;
      lock_prev = 1'b0;
      test_reset();
      test_default_cadence();
      test_write_apply();
      test_back_to_back();
      test_div_one();
      test_reset_mid();
      test_default_cadence();
      test_sync();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised single-domain clock-enable generator, run from the 100 MHz board clock.
- Produces NUM_CH divided enable strobes and registered square-wave references, with run-time divisor reprogramming and channel realignment.
- A lock indicator emulates PLL relock behaviour, so downstream logic (VGA timing, Mandelbrot core) runs off clk100 with qualified enables instead of extra global clocks.
- Defaults reproduce the 25/50 MHz rates.

Parameters:
NUM_CH, 2, number of enable channels (1..8)
DIV_W, 8, divisor width in bits
DIV_INIT, {8'd2, 8'd4}, packed NUM_CH*DIV_W reset divisors; channel i in bits [i*DIV_W +: DIV_W] (ch0=4 gives 25 MHz, ch1=2 gives 50 MHz)
LOCK_CYCLES, 16, cycles locked stays low after reset, divisor change or sync (>=1)

Ports:
clk100  in  1  system clock
rst  in  1  reset, synchronous, active-high
div_wr_valid  in  1  divisor write request
div_wr_ready  out  1  write accepted when valid & ready
div_wr_ch  in  max(1,$clog2(NUM_CH))  target channel
div_wr_val  in  DIV_W  new divisor
sync_req  in  1  single-cycle pulse: realign all channels
en  out  NUM_CH  one-cycle enable strobes
sq  out  NUM_CH  registered square reference, toggles per strobe (data only, never a clock)
locked  out  1  outputs valid and stable

Behaviour:
- Reset: the only clock is clk100; reset is synchronous and active-high on rst.
  - cnt[i]=0, div[i]=DIV_INIT slice, pend[i]=0, sq=0, locked=0, lock_cnt=0, state=WAIT.
  - en=0 and div_wr_ready=0 during reset.
  - Reset asserted mid-operation discards pending writes and restores DIV_INIT.
- Effective divisor: d[i] = (div[i] <= 1) ? 1 : div[i].
- Counter: cnt[i] increments every cycle and wraps from d[i]-1 to 0. Counters run in both states.
- Terminal count: tc[i] = (cnt[i] == d[i]-1).
- Enable: en[i] = locked & tc[i] (decoded from registers, zero added latency). With d=1, en[i] is constantly 1 while locked.
- Square reference: sq[i] toggles on every tc[i], gated or not, and is registered.
- State machine (clk_en_pkg::state_t):
  - WAIT: lock_cnt increments each cycle. When lock_cnt==LOCK_CYCLES-1, go to RUN and set locked=1 next cycle. First cycle after rst deasserts is cycle 0; locked=1 at cycle LOCK_CYCLES.
  - RUN: locked=1. Go to WAIT (lock_cnt=0, locked=0 next cycle) on any divisor apply or sync_req.
- Divisor write handshake:
  - div_wr_ready = !rst & !pend[div_wr_ch]. Ready is 1 for out-of-range channels.
  - On accept, the value is staged: pend=1, pval=div_wr_val. Out-of-range channels are accepted and dropped.
  - Accepted in RUN or WAIT.
- Apply: pending value loads into div[i] at the next tc[i] strictly after the accept cycle. At that edge cnt wraps to 0 and pend clears. No period is ever truncated.
  - Write equal to current div: still applied and still triggers relock.
  - Same-cycle apply on multiple channels: a single relock.
- sync_req, highest priority after rst:
  - Next cycle: all cnt=0 and all sq=0.
  - All pending values are applied immediately and pend cleared.
  - state=WAIT, lock_cnt=0, locked=0.
  - A simultaneous div_wr accept is staged and not applied by this sync.
- sync_req or an apply during WAIT restarts lock_cnt from 0.

Decomposition:
- clk_en_pkg holds: state_t enum {WAIT, RUN}, DIV_W_DEF=8, LOCK_CYCLES_DEF=16, and function eff_div (0/1 maps to 1).
- Sub-module clk_en_chan, instantiated per channel via generate, owns cnt, div, pend, pval and sq.
  - Inputs: sync, accept, value, locked.
  - Outputs: tc, applied, en, sq, pend.
- Top level owns the lock FSM, channel decode and ready mux.

Test Plan:
1. Default reset, no traffic: locked rises at cycle 16. en[0] high at cycles 19,23,27. en[1] high at 17,19,21. sq[0] period 8 cycles.
2. In RUN, write ch0=8 at cycle 40 (ready=1). Required response:
   - old period completes, apply at tc cycle 43;
   - cnt[0]=0 at 44 and locked=0 from 44 to 59, back to 1 at 60;
   - en[0] next at 67, then every 8 cycles;
   - ch1 cadence is unaffected.
3. Back-to-back writes to ch1 (3 then 5): ready drops after the first accept until its apply. The second value applies at the following tc. Each apply relocks, and no en period is shorter than the old divisor.
4. Write ch0=0 and ch1=1: after relock, en=2'b11 every cycle and sq toggles every cycle.
5. sync_req at an arbitrary RUN cycle T with a pending ch0 write:
   - cnt=0 and sq=0 at T+1;
   - div[0] updated at T+1, pend clear;
   - locked low during T+1..T+16;
   - en[0] and en[1] rising coincident afterwards.
6. rst asserted for 1 cycle mid-operation with pending writes: all outputs return to reset values, div restored to 4/2, pend=0, and the sequence of scenario 1 repeats.
